// File: rtl/rs232_ser_pkg.sv
// Shared definitions for the RS232 serializer: FSM state encoding, frame constants
// and baud divider / counter width helpers.
package rs232_ser_pkg;

   localparam int unsigned LP_DATA_BITS       = 8;
   localparam int unsigned LP_DEF_CLK_FREQ_HZ = 50_000_000;
   localparam int unsigned LP_DEF_BAUD_RATE   = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   // Truncating divider: no fractional baud correction.
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/rs232_ser_baud_gen.sv
// Bit-period counter: counts 0..P_DIV-1 while enabled and strobes o_bit_done_c on the
// last cycle of each bit; synchronous clear restarts the bit period.
module rs232_ser_baud_gen
   import rs232_ser_pkg::*;
#(
   parameter int unsigned P_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_bit_done_c
);

   localparam int unsigned LP_CNT_W = cnt_width(P_DIV);

   logic [LP_CNT_W-1:0] r_cnt;
   logic                w_bit_done;

   assign w_bit_done   = i_en && (r_cnt == LP_CNT_W'(P_DIV - 1));
   assign o_bit_done_c = w_bit_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || w_bit_done) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + LP_CNT_W'(1);
      end
   end

endmodule

// File: rtl/rs232_ser.sv
// RS232 8N1 transmit serializer draining an external TX FIFO (normal read mode).
// Optional RS232_SER_CTS_EN: gate FIFO reads on a synchronized active-low cts_n.
module rs232_ser
   import rs232_ser_pkg::*;
#(
   parameter int unsigned P_CLK_FREQ_HZ = LP_DEF_CLK_FREQ_HZ,
   parameter int unsigned P_BAUD_RATE   = LP_DEF_BAUD_RATE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LP_DATA_BITS-1:0] tx_fifo_data,
   input  logic                    tx_fifo_empty,
   output logic                    tx_fifo_rd_en,
   input  logic                    cts_n,
   output logic                    tx,
   output logic                    busy
);

   localparam int unsigned LP_DIV   = baud_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
   localparam int unsigned LP_IDX_W = $clog2(LP_DATA_BITS);

   state_t                  r_state, w_state_nxt;
   logic [LP_DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [LP_IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
   logic                    r_tx, w_tx_nxt;
   logic                    r_armed;
   logic                    w_cts_ok;
   logic                    w_rd_en;
   logic                    w_bit_done;
   logic                    w_baud_en;
   logic                    w_baud_clr;

`ifdef RS232_SER_CTS_EN
   logic [1:0] r_cts_sync;

   // Resets to "not clear" so nothing is read until CTS is seen low twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cts_sync <= 2'b11;
      end else begin
         r_cts_sync <= {r_cts_sync[0], cts_n};
      end
   end

   assign w_cts_ok = ~r_cts_sync[1];
`else
   logic w_unused_cts;

   assign w_unused_cts = cts_n;
   assign w_cts_ok     = 1'b1;
`endif

   // Blocks a read during reset while the state register sits in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   // The read request must fall in the IDLE cycle itself so data is valid in LOAD.
   assign w_rd_en       = r_armed && (r_state == ST_IDLE) && !tx_fifo_empty && w_cts_ok;
   assign tx_fifo_rd_en = w_rd_en;
   assign busy          = w_rd_en || (r_state != ST_IDLE);
   assign tx            = r_tx;

   assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
   assign w_baud_clr = (r_state == ST_LOAD);

   rs232_ser_baud_gen #(
      .P_DIV (LP_DIV)
   ) u_baud_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (w_baud_en),
      .i_clr        (w_baud_clr),
      .o_bit_done_c (w_bit_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      w_tx_nxt      = 1'b1;

      unique case (r_state)
         ST_IDLE: begin
            if (w_rd_en) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_shift_nxt   = tx_fifo_data;
            w_bit_idx_nxt = '0;
            w_state_nxt   = ST_START;
         end
         ST_START: begin
            if (w_bit_done) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_bit_done) begin
               w_shift_nxt = {1'b0, r_shift[LP_DATA_BITS-1:1]};
               if (r_bit_idx == LP_IDX_W'(LP_DATA_BITS - 1)) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + LP_IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (w_bit_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Line level follows the state being entered, so tx changes exactly on bit edges.
      unique case (w_state_nxt)
         ST_START: w_tx_nxt = 1'b0;
         ST_DATA:  w_tx_nxt = w_shift_nxt[0];
         default:  w_tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_rs232_ser.sv
// Self-checking bench for rs232_ser: FIFO model, mid-bit sampling receiver with a
// scoreboard, a frame vector table and hand-written timing/reset/CTS sequences.
module tb_rs232_ser;

   localparam int DIV   = 434;
   localparam int FRAME = 10 * DIV + 2;
   localparam int LIMIT = 3 * FRAME;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] fifo_q = 8'h00;
   logic       fifo_empty = 1'b1;
   logic       rd_en;
   logic       cts_n;
   logic       tx;
   logic       busy;

   byte unsigned fifo_m[$];
   byte unsigned sb[$];
   int unsigned  rd_cyc[$];
   byte unsigned rd_byte;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   int          rd_cnt  = 0;
   int          rx_frames = 0;

   logic        rx_busy = 1'b0;
   int          rx_cnt  = 0;
   int          rx_bit  = 0;
   logic [7:0]  rx_sh   = 8'h00;

   always #5 clk = ~clk;

   rs232_ser dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_fifo_data  (fifo_q),
      .tx_fifo_empty (fifo_empty),
      .tx_fifo_rd_en (rd_en),
      .cts_n         (cts_n),
      .tx            (tx),
      .busy          (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // FIFO model: normal read mode, q valid the cycle after rd_en.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en === 1'b1) begin
         rd_cnt <= rd_cnt + 1;
         rd_cyc.push_back(cyc);
         check("rd_while_empty", 32'(fifo_empty), 32'd0);
         if (fifo_m.size() != 0) begin
            rd_byte = fifo_m.pop_front();
            fifo_q <= rd_byte;
            sb.push_back(rd_byte);
         end
      end
      fifo_empty <= (fifo_m.size() == 0);
   end

   // Receiver: samples each bit mid-period and checks against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt = rx_cnt + 1;
         if (rx_cnt % DIV == DIV / 2) begin
            rx_bit = rx_cnt / DIV;
            if (rx_bit == 0) begin
               check("rx_start_bit", 32'(tx), 32'd0);
            end else if (rx_bit <= 8) begin
               rx_sh[rx_bit-1] = tx;
            end else begin
               check("rx_stop_bit", 32'(tx), 32'd1);
               rx_frames++;
               check("rx_sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) check("rx_byte", 32'(rx_sh), 32'(sb.pop_front()));
               rx_busy = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b);
      fifo_m.push_back(b);
   endtask

   task automatic wait_idle(input string name);
      int n;
      for (n = 0; n < LIMIT; n++) begin
         @(negedge clk);
         if (!busy && !rx_busy && fifo_m.size() == 0 && sb.size() == 0) break;
      end
      check({name, "_idle"}, 32'(n < LIMIT), 32'd1);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 2 * FRAME; n++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic capture_frame(output logic [9:0] f, output bit ok);
      int c;
      f = '0;
      wait_start(ok);
      c = 0;
      for (int j = 0; j < 10; j++) begin
         while (c < j * DIV + DIV / 2) begin
            @(negedge clk);
            c++;
         end
         f[j] = tx;
      end
   endtask

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: simulation ran past its cycle budget");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[5];
      logic [9:0] f;
      logic [9:0] exp_f;
      bit         ok;
      int         base, fr, len, n;

      vecs[0] = '{data: 8'h00, frame: 10'h200};
      vecs[1] = '{data: 8'hFF, frame: 10'h3FE};
      vecs[2] = '{data: 8'h01, frame: 10'h202};
      vecs[3] = '{data: 8'h80, frame: 10'h300};
      vecs[4] = '{data: 8'h6B, frame: 10'h2D6};

      // Reset with a non-empty FIFO: line idle, no read, not busy.
      rst_n = 1'b0;
      cts_n = 1'b0;
      push(8'h11);
      repeat (8) begin
         @(negedge clk);
         check("reset_tx_rd_busy", 32'({tx, rd_en, busy}), 32'h4);
      end
      rst_n = 1'b1;
      wait_idle("after_reset");

      // 0x55: every bit exactly DIV cycles, busy drops right after stop.
      base  = rd_cnt;
      exp_f = {1'b1, 8'h55, 1'b0};
      push(8'h55);
      wait_start(ok);
      check("t2_start_seen", 32'(ok), 32'd1);
      for (int k = 0; k < 10; k++) begin
         len = 0;
         while (tx === exp_f[k] && (k < 9 || busy === 1'b1) && len < 2 * DIV) begin
            len++;
            @(negedge clk);
         end
         check($sformatf("t2_bit%0d_len", k), 32'(len), 32'(DIV));
      end
      check("t2_busy_after_stop", 32'(busy), 32'd0);
      check("t2_rd_pulses", 32'(rd_cnt - base), 32'd1);
      wait_idle("t2");

      // Back-to-back bytes: reads spaced one full frame period apart.
      rd_cyc.delete();
      fr = rx_frames;
      push(8'hA5);
      push(8'h3C);
      wait_idle("t3");
      check("t3_reads", 32'(rd_cyc.size()), 32'd2);
      if (rd_cyc.size() == 2) check("t3_spacing", rd_cyc[1] - rd_cyc[0], 32'(FRAME));
      check("t3_frames", 32'(rx_frames - fr), 32'd2);

      // Frame vector table.
      for (int i = 0; i < 5; i++) begin
         push(vecs[i].data);
         capture_frame(f, ok);
         check($sformatf("vec%0d_start_seen", i), 32'(ok), 32'd1);
         check($sformatf("vec%0d_frame", i), 32'(f), 32'(vecs[i].frame));
         wait_idle($sformatf("vec%0d", i));
      end

      // Reset mid-DATA: line high immediately, in-flight byte dropped, next byte intact.
      base = rd_cnt;
      fr   = rx_frames;
      push(8'hFF);
      wait_start(ok);
      repeat (4 * DIV) @(negedge clk);
      check("t5_inflight", 32'(sb.size()), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_tx_async", 32'(tx), 32'd1);
      check("t5_busy_async", 32'(busy), 32'd0);
      sb.delete();
      push(8'h42);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_idle("t5");
      check("t5_reads", 32'(rd_cnt - base), 32'd2);
      check("t5_frames", 32'(rx_frames - fr), 32'd1);

`ifdef RS232_SER_CTS_EN
      // CTS gating: held while not clear, mid-frame deassertion never truncates.
      base = rd_cnt;
      fr   = rx_frames;
      cts_n = 1'b1;
      push(8'h81);
      repeat (40) @(negedge clk);
      check("t4_held_rd", 32'(rd_cnt - base), 32'd0);
      check("t4_held_tx", 32'(tx), 32'd1);
      cts_n = 1'b0;
      n = 0;
      while (rd_en !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t4_rd_latency", 32'(n <= 3), 32'd1);
      wait_start(ok);
      repeat (3 * DIV) @(negedge clk);
      push(8'h7E);
      cts_n = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < FRAME) begin
         @(negedge clk);
         n++;
      end
      check("t4_frame_done", 32'(rx_frames - fr), 32'd1);
      repeat (100) @(negedge clk);
      check("t4_next_held", 32'(rd_cnt - base), 32'd1);
      check("t4_idle_tx", 32'(tx), 32'd1);
      cts_n = 1'b0;
      wait_idle("t4");
      check("t4_reads", 32'(rd_cnt - base), 32'd2);
`endif

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
